// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B (mod 2^WIDTH) and borrow-out, one bit per clock, LSB first.
// A start/done handshake wraps each operation; Diff/Bout hold between completions.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] r_d;
  logic             last_bit;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic borrow_next(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  // One full-subtractor cell applied to the operand LSBs each RUN cycle
  always_comb begin
    d_bit    = diff_bit(a_q[0], b_q[0], br_q);
    br_d     = borrow_next(a_q[0], b_q[0], br_q);
    r_d      = {d_bit, r_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // The result register is complete only after the MSB bit lands
          if (last_bit) begin
            diff_q  <= r_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor pops on each done pulse.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Diff;
  logic       Bout;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   done_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Diff  (Diff),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Diff=%0h Bout=%0b expected no completion", Diff, Bout);
      end else begin
        e = exp_q.pop_front();
        chk("diff", 32'(Diff), 32'(e.d));
        chk("bout", 32'(Bout), 32'(e.bo));
        chk("diff_plus_b", 32'(8'(Diff + e.b)), 32'(e.a));
        chk("bout_vs_lt", 32'(Bout), 32'(e.a < e.b));
        chk("busy_during_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one request and return how many sampled cycles busy stayed high
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic bo, output int busy_cycles);
    int n;
    wait_idle();
    start = 1'b1;
    A     = a;
    B     = b;
    exp_q.push_back('{a: a, b: b, d: d, bo: bo});
    @(negedge clk);
    start = 1'b0;
    A     = 8'h5C;
    B     = 8'hC5;
    n     = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    busy_cycles = n;
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[8] = '{
    '{8'h03, 8'h02, 8'h01, 1'b0},
    '{8'h01, 8'h02, 8'hFF, 1'b1},
    '{8'h81, 8'h81, 8'h00, 1'b0},
    '{8'h00, 8'hFF, 8'h01, 1'b1},
    '{8'hFF, 8'h00, 8'hFF, 1'b0},
    '{8'hA5, 8'h5A, 8'h4B, 1'b0},
    '{8'h5A, 8'hA5, 8'hB5, 1'b1},
    '{8'h80, 8'h01, 8'h7F, 1'b0}
  };

  initial begin
    int bc;
    int dc0;
    logic [7:0] ta;
    logic [7:0] tb;
    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_diff", 32'(Diff), 32'h0);
    chk("reset_bout", 32'(Bout), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h01, 8'h01, 8'h00, 1'b0, bc);
    chk("busy_cycles", 32'(bc), 32'd9);
    chk("done_count_first", 32'(done_cnt), 32'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, bc);
      chk("busy_cycles_vec", 32'(bc), 32'd9);
    end

    // A second request during RUN must be dropped
    wait_idle();
    dc0   = done_cnt;
    start = 1'b1;
    A     = 8'h19;
    B     = 8'h31;
    exp_q.push_back('{a: 8'h19, b: 8'h31, d: 8'hE8, bo: 1'b1});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    A     = 8'h05;
    B     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("ignored_start_done_pulses", 32'(done_cnt - dc0), 32'd1);
    chk("ignored_start_diff_hold", 32'(Diff), 32'hE8);

    // Asynchronous reset mid-operation abandons it
    dc0   = done_cnt;
    start = 1'b1;
    A     = 8'h32;
    B     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_diff", 32'(Diff), 32'h0);
    chk("async_rst_bout", 32'(Bout), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt - dc0), 32'd0);
    do_op(8'h32, 8'h11, 8'h21, 1'b0, bc);
    chk("post_reset_busy_cycles", 32'(bc), 32'd9);

    // start held high: one accept every 10 cycles, operands changing each cycle
    wait_idle();
    dc0 = done_cnt;
    for (int k = 0; k < 30; k++) begin
      ta    = 8'(k * 37 + 5);
      tb    = 8'(k * 53 + 11);
      start = 1'b1;
      A     = ta;
      B     = tb;
      if (k % 10 == 0) exp_q.push_back('{a: ta, b: tb, d: 8'(ta - tb), bo: (ta < tb)});
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("b2b_done_pulses", 32'(done_cnt - dc0), 32'd3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
